// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package freq_div_pkg;

  localparam int unsigned MIN_DIV     = 2;
  localparam int          DEF_CNT_W   = 8;
  localparam int          DEF_DIV_VAL = 3;

  function automatic int unsigned clamp_div(input int unsigned n);
    return (n < MIN_DIV) ? MIN_DIV : n;
  endfunction

  function automatic int unsigned half_ceil(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/freq_div_n_if.sv
// Control/status bundle between a divider and its configuring logic.
interface freq_div_n_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             cout;
  logic             tick;
  logic [CNT_W-1:0] cur_div;
  logic             cfg_err;

  modport master (
    output en, div_val,
    input  cout, tick, cur_div, cfg_err
  );

  modport slave (
    input  en, div_val,
    output cout, tick, cur_div, cfg_err
  );
endinterface

// File: rtl/freq_div_negedge_retime.sv
// Single falling-edge flop used to delay the posedge-domain level by half a clock.
module freq_div_negedge_retime (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) q_o <= 1'b0;
    else     q_o <= d_i;
  end

endmodule

// File: rtl/freq_div_n.sv
// Runtime-programmable integer clock divider with 50% duty output and period tick.
// FREQ_DIV_DUTY_CORR_EN adds the falling-edge correction for odd divisors.
module freq_div_n
  import freq_div_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic          clk,
  input  logic          rst,
  freq_div_n_if.slave   bus
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] div_req, last_cnt, half;
  logic             run_q;
  logic             p_out_q, p_out_d;
  logic             tick_q, tick_d;
  logic             wrap, boundary;

  always_comb begin
    div_req  = CNT_W'(clamp_div(32'(bus.div_val)));
    last_cnt = div_q - CNT_W'(1);
    half     = CNT_W'(half_ceil(32'(div_q)));
    wrap     = (cnt_q == last_cnt);
    // A fresh start after en was low also opens a period, so it may load too.
    boundary = !bus.en || !run_q || wrap;
    div_d    = boundary ? div_req : div_q;
    cnt_d    = boundary ? '0 : cnt_q + CNT_W'(1);
    p_out_d  = bus.en && (cnt_d < half);
    tick_d   = bus.en && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      div_q   <= DEF_DIV_C;
      run_q   <= 1'b0;
      p_out_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      run_q   <= bus.en;
      p_out_q <= p_out_d;
      tick_q  <= tick_d;
    end
  end

`ifdef FREQ_DIV_DUTY_CORR_EN
  logic n_out;

  freq_div_negedge_retime u_retime (
    .clk (clk),
    .rst (rst),
    .d_i (p_out_q),
    .q_o (n_out)
  );

  // Odd divisors: AND with the half-cycle-late copy moves the rising edge to a negedge.
  assign bus.cout = div_q[0] ? (p_out_q & n_out) : p_out_q;
`else
  assign bus.cout = p_out_q;
`endif

  assign bus.tick    = tick_q;
  assign bus.cur_div = div_q;
  assign bus.cfg_err = (bus.div_val < CNT_W'(MIN_DIV));

endmodule

// File: tb/tb_freq_div_n.sv
// Directed self-checking bench for freq_div_n; expectations follow the build's duty-correction setting.
module tb_freq_div_n;

`ifdef FREQ_DIV_DUTY_CORR_EN
  localparam bit CORR = 1'b1;
`else
  localparam bit CORR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  logic [63:0] pos_v, neg_v, tick_v;

  freq_div_n_if #(.CNT_W(8)) bus_if ();

  freq_div_n #(.CNT_W(8), .DEF_DIV(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Records cout after each posedge and negedge, and tick after each posedge; first cycle ends up MSB.
  task automatic run(input int n);
    pos_v  = '0;
    neg_v  = '0;
    tick_v = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pos_v  = {pos_v[62:0], bus_if.cout};
      tick_v = {tick_v[62:0], bus_if.tick};
      @(negedge clk); #1;
      neg_v  = {neg_v[62:0], bus_if.cout};
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.en = 1'b0;
    bus_if.div_val = 8'd3;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rst_cout", 64'(bus_if.cout), 64'd0);
    chk("rst_tick", 64'(bus_if.tick), 64'd0);
    chk("rst_cur_div", 64'(bus_if.cur_div), 64'd3);
    chk("rst_cfg_err", 64'(bus_if.cfg_err), 64'd0);

    @(negedge clk); #1;
    rst = 1'b0;
    bus_if.en = 1'b1;
    run(6);
    chk("n3_pos", pos_v, CORR ? 64'b010010 : 64'b110110);
    chk("n3_neg", neg_v, 64'b110110);
    chk("n3_tick", tick_v, 64'b100100);
    chk("n3_cur_div", 64'(bus_if.cur_div), 64'd3);

    bus_if.div_val = 8'd4;
    run(8);
    chk("n4_pos", pos_v, 64'b11001100);
    chk("n4_neg", neg_v, 64'b11001100);
    chk("n4_tick", tick_v, 64'b10001000);
    chk("n4_cur_div", 64'(bus_if.cur_div), 64'd4);

    run(2);
    chk("n4b_tick", tick_v, 64'b10);
    bus_if.div_val = 8'd5;
    run(2);
    chk("mid_chg_pos", pos_v, 64'b00);
    chk("mid_chg_cur_div", 64'(bus_if.cur_div), 64'd4);
    run(10);
    chk("n5_pos", pos_v, CORR ? 64'b0110001100 : 64'b1110011100);
    chk("n5_neg", neg_v, 64'b1110011100);
    chk("n5_tick", tick_v, 64'b1000010000);
    chk("n5_cur_div", 64'(bus_if.cur_div), 64'd5);

    bus_if.div_val = 8'd1;
    #1;
    chk("clamp_cfg_err", 64'(bus_if.cfg_err), 64'd1);
    run(6);
    chk("clamp_pos", pos_v, 64'b101010);
    chk("clamp_neg", neg_v, 64'b101010);
    chk("clamp_tick", tick_v, 64'b101010);
    chk("clamp_cur_div", 64'(bus_if.cur_div), 64'd2);

    bus_if.div_val = 8'd6;
    #1;
    chk("n6_cfg_err", 64'(bus_if.cfg_err), 64'd0);
    run(2);
    chk("n6_pre_pos", pos_v, 64'b11);
    bus_if.en = 1'b0;
    run(2);
    chk("en_off_pos", pos_v, 64'b00);
    chk("en_off_neg", neg_v, 64'b00);
    chk("en_off_tick", tick_v, 64'b00);
    bus_if.en = 1'b1;
    run(7);
    chk("en_on_pos", pos_v, 64'b1110001);
    chk("en_on_neg", neg_v, 64'b1110001);
    chk("en_on_tick", tick_v, 64'b1000001);
    chk("n6_cur_div", 64'(bus_if.cur_div), 64'd6);

    bus_if.div_val = 8'd7;
    bus_if.en = 1'b0;
    run(1);
    chk("n7_load_cur_div", 64'(bus_if.cur_div), 64'd7);
    bus_if.en = 1'b1;
    run(8);
    chk("n7_pos", pos_v, CORR ? 64'b01110000 : 64'b11110001);
    chk("n7_neg", neg_v, 64'b11110001);
    chk("n7_tick", tick_v, 64'b10000001);

    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_cout", 64'(bus_if.cout), 64'd0);
    chk("async_rst_tick", 64'(bus_if.tick), 64'd0);
    chk("async_rst_cur_div", 64'(bus_if.cur_div), 64'd3);
    @(posedge clk); #1;
    chk("rst_hold_cout", 64'(bus_if.cout), 64'd0);
    chk("rst_hold_tick", 64'(bus_if.tick), 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    run(7);
    chk("post_rst_pos", pos_v, CORR ? 64'b0111000 : 64'b1111000);
    chk("post_rst_neg", neg_v, 64'b1111000);
    chk("post_rst_tick", tick_v, 64'b1000000);
    chk("post_rst_cur_div", 64'(bus_if.cur_div), 64'd7);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/freq_div_n.md
Name: freq_div_n

Overview:
- Parametrised, runtime-programmable integer clock divider; successor to the fixed divide-by-3 block.
- Produces a 50%-duty divided clock `cout` for any divisor N >= 2, odd or even, from one input clock.
- Also produces a single-cycle terminal-count strobe `tick` for synchronous consumers.
- Sits in the clocking/utility layer and feeds timers, baud generators and LED/scan logic.

Parameters:
- CNT_W, 8: width of the divisor and the internal counter; max divisor is 2^CNT_W-1.
- DEF_DIV, 3: divisor applied out of reset; must be >= 2 and < 2^CNT_W.

Ports:
- clk  in  1  input clock; the only clock.
- rst  in  1  asynchronous, active-high reset; applies to every flop on both clock edges.
- en  in  1  divider enable; sampled on posedge clk.
- div_val  in  CNT_W  requested divisor N.
- cout  out  1  divided clock.
- tick  out  1  one-clk-cycle pulse at the start of each output period; posedge domain.
- cur_div  out  CNT_W  divisor currently in effect.
- cfg_err  out  1  high while div_val < 2.

Behaviour:
- Reset values: cnt=0, div_q=DEF_DIV, p_out=0, n_out=0, cout=0, tick=0, cur_div=DEF_DIV. cfg_err is combinational from div_val.
- Divisor clamp: if div_val is 0 or 1, the effective request is 2.
- Divisor load: div_q loads the clamped div_val only at a period boundary. A boundary is a posedge where cnt==div_q-1 with en=1, or any posedge where en=0.
- Mid-period changes to div_val have no effect until the next boundary. cur_div = div_q.
- Counter: on each posedge with en=1, cnt <= (cnt==div_q-1) ? 0 : cnt+1.
- Counter with en=0: cnt <= 0, p_out <= 0, tick <= 0.
- H = ceil(div_q/2).
- p_out is a posedge register: p_out <= en & (next_cnt < H).
- tick is a posedge register: tick <= en & (next_cnt == 0).
- n_out <= p_out on negedge clk, i.e. p_out delayed by a half cycle.
- Even N: cout = p_out. High for N/2 clk cycles, low for N/2.
- Odd N: cout = p_out & n_out. High for N/2 cycles (fractional), 50% duty; the rising edge lands on a negedge.
- The even/odd select uses div_q[0], so it changes only at boundaries.
- No glitch on cout at a divisor change; the first period after a load uses the new N in full.
- Startup: first posedge with en=1 gives cnt=0, tick=1, p_out=1.
  - Even N: cout rises at that posedge.
  - Odd N: cout rises at the following negedge.
- en deassert: cout falls within 1 clk cycle and stays low; en reassert starts a fresh period.
- rst mid-period: everything clears immediately (asynchronously) on both edge domains; div_q returns to DEF_DIV.

Optional Feature:
- Macro: FREQ_DIV_DUTY_CORR_EN.
- Defined: negedge half-cycle correction present; odd-N duty is 50% as described above.
- Undefined:
  - No negedge flops are built; cout = p_out for all N.
  - Odd N duty is H/N (e.g. N=3 gives 2 cycles high, 1 low).
  - All other behaviour is unchanged, and the design is single-edge for DFT/STA simplicity.

Decomposition:
- Package freq_div_pkg holds:
  - MIN_DIV=2;
  - default CNT_W/DEF_DIV constants;
  - function clamp_div (returns MIN_DIV if input < MIN_DIV);
  - function half_ceil (N+1)>>1.
- One sub-module, freq_div_negedge_retime: a 1-bit negedge flop with async active-high reset. It is instantiated only under FREQ_DIV_DUTY_CORR_EN.

Test Plan:
- Reset release, en=1, div_val=3 (correction on) -> cout period 3 clk; high 1.5 clk measured from negedge to posedge; tick every 3rd posedge; cur_div=3.
- div_val=4 -> cout high exactly 2 clk, low 2 clk, rising on posedge; tick period 4.
- Running N=4; at cnt=1 set div_val=5 -> current period completes at 4 clk; next period 5 clk with 2.5 clk high; cur_div switches to 5 at the boundary posedge.
- div_val=1 -> cfg_err=1; behaves as N=2 (cout toggles every clk); cur_div=2.
- en dropped mid-high with N=6 -> cout low within 1 clk, tick=0; en high again -> tick on first posedge and a full 3-high/3-low period.
- Assert rst asynchronously mid-period with N=7 and between edges -> cout, tick, cnt drop to 0 immediately; cur_div=DEF_DIV. Same N=7 run without FREQ_DIV_DUTY_CORR_EN -> 4 high / 3 low.
